mux_rr_arbiter: RTL

//  Round-robin, packet-locked arbiter that shares one W-bit output channel between N

---
 rtl/mux_arb_pkg.sv | 20 ++
 rtl/rr_prio_pick.sv | 46 ++++
 rtl/mux_rr_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin packet arbiter.
// Holds the arbiter state encoding and a one-hot to index converter.
package mux_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Returns the index of the set bit; the caller guarantees at most one bit is set.
  function automatic logic [4:0] onehot2idx(input logic [31:0] onehot);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (onehot[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational rotating-priority picker: the first request after ptr wins.
// Rotates the request vector to start at ptr+1, priority-encodes, then rotates back.
module rr_prio_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick_onehot,
  output logic          any
);

  logic [N-1:0] rot;
  logic [N-1:0] rot_pick;

  always_comb begin
    int   start;
    int   idx;
    logic found;
    rot         = '0;
    rot_pick    = '0;
    pick_onehot = '0;
    found       = 1'b0;
    // N need not be a power of two, so the wrap is an explicit compare.
    start = (int'(ptr) >= N - 1) ? 0 : int'(ptr) + 1;
    for (int k = 0; k < N; k++) begin
      idx = start + k;
      if (idx >= N) idx = idx - N;
      rot[k] = req[idx];
    end
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        rot_pick[k] = 1'b1;
        found       = 1'b1;
      end
    end
    for (int k = 0; k < N; k++) begin
      idx = start + k;
      if (idx >= N) idx = idx - N;
      pick_onehot[idx] = rot_pick[k];
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Packet-locked round-robin arbiter sharing one valid/ready channel between N requesters.
// Grant is held until last, or until MAX_BEATS beats force a release (flagged in trunc_err).
//
//   state | meaning
//   IDLE  | no grant; arbitrate among req_valid, lock the winner next cycle
//   LOCK  | granted requester passes straight through until a last beat
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_valid,
  input  logic [W-1:0] req_data [N],
  input  logic [N-1:0] req_last,
  output logic [N-1:0] req_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  input  logic         out_ready,
  output logic [N-1:0] grant,
  output logic         busy,
  output logic         trunc_err
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam logic [BW-1:0] LAST_CNT = BW'(MAX_BEATS - 1);

  arb_state_e    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic          trunc_err_q, trunc_err_d;

  logic [N-1:0]  pick_onehot;
  logic          pick_any;
  logic          sel_valid, sel_last;
  logic [W-1:0]  sel_data;
  logic          locked, beat;

  rr_prio_pick #(.N(N), .PW(PW)) u_pick (
    .req         (req_valid),
    .ptr         (ptr_q),
    .pick_onehot (pick_onehot),
    .any         (pick_any)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N; i++) begin
      sel_valid = sel_valid | (req_valid[i] & grant_q[i]);
      sel_last  = sel_last  | (req_last[i]  & grant_q[i]);
      sel_data  = sel_data  | (req_data[i]  & {W{grant_q[i]}});
    end
  end

  // Reset drops the pass-through immediately rather than waiting for the clock edge.
  assign locked    = (state_q == LOCK) && !rst;
  assign out_valid = locked & sel_valid;
  assign out_data  = locked ? sel_data : '0;
  assign out_last  = locked & (sel_last | (beat_cnt_q == LAST_CNT));
  assign req_ready = (locked && out_ready) ? grant_q : '0;
  assign beat      = out_valid & out_ready;

  assign grant     = grant_q;
  assign busy      = locked;
  assign trunc_err = trunc_err_q;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    beat_cnt_d  = beat_cnt_q;
    trunc_err_d = trunc_err_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = LOCK;
          grant_d    = pick_onehot;
          ptr_d      = PW'(onehot2idx(32'(pick_onehot)));
          beat_cnt_d = '0;
        end
      end
      LOCK: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (out_last) begin
            state_d = IDLE;
            grant_d = '0;
            if (!sel_last) trunc_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ptr_q       <= PW'(N - 1);
      beat_cnt_q  <= '0;
      trunc_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      trunc_err_q <= trunc_err_d;
    end
  end

  a_grant_onehot0: assert property (@(posedge clk) $onehot0(grant_q))
    else $error("grant is not one-hot or zero");

endmodule
